// File: rtl/ptw_req_arbiter.sv
// ptw_req_arbiter
//
// Shares one page-table walker between NrRequesters TLB-miss sources
// (default: index 0 = ITLB, index 1 = DTLB). Requests are granted
// round-robin with a single walk outstanding. The walk result is routed back
// to the granted requester as a one-cycle pulse. A flush aborts the pending or
// outstanding walk. A watchdog fails a walk that never completes.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   flush_i          abort pending/outstanding walk
//   req_valid_i      per-requester miss request, held until its response
//   req_vaddr_i      packed miss vaddrs, slice i belongs to requester i
//   resp_valid_o     one-cycle completion pulse for the granted requester
//   resp_error_o     walk faulted or timed out (qualified by resp_valid_o)
//   ptw_valid_o      walk request to the PTW (valid/ready handshake)
//   ptw_ready_i      PTW accepts the request
//   ptw_vaddr_o      latched vaddr of the granted requester
//   ptw_id_o         granted requester index
//   ptw_done_i       walk completed (single-cycle pulse)
//   ptw_error_i      walk fault, valid with ptw_done_i
//   busy_o           arbiter is not idle
module ptw_req_arbiter #(
    parameter int unsigned NrRequesters  = 2,
    parameter int unsigned VLEN          = 39,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned IdW           = $clog2(NrRequesters)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NrRequesters-1:0]      req_valid_i,
    input  logic [NrRequesters*VLEN-1:0] req_vaddr_i,
    output logic [NrRequesters-1:0]      resp_valid_o,
    output logic                         resp_error_o,
    output logic                         ptw_valid_o,
    input  logic                         ptw_ready_i,
    output logic [VLEN-1:0]              ptw_vaddr_o,
    output logic [IdW-1:0]               ptw_id_o,
    input  logic                         ptw_done_i,
    input  logic                         ptw_error_i,
    output logic                         busy_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_e;

    state_e                    state_q, state_d;
    logic [IdW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]            grant_id_q, grant_id_d;
    logic [VLEN-1:0]           vaddr_q, vaddr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [NrRequesters-1:0]   resp_valid_q, resp_valid_d;
    logic                      resp_error_q, resp_error_d;
    logic                      ptw_valid_q, ptw_valid_d;
    logic                      busy_q, busy_d;

    logic [NrRequesters-1:0]   eligible;
    logic                      pick_found;
    logic [IdW-1:0]            pick_id;
    logic [VLEN-1:0]           pick_vaddr;
    logic                      handshake;
    logic                      timeout;
    logic [NrRequesters-1:0]   grant_onehot;

    // Round-robin pick. A requester sees its response one cycle before it can
    // drop req_valid_i, so the bit being answered this cycle is masked off.
    // Pass one searches from rr_ptr upward; pass two wraps to the low indices.
    always_comb begin
        eligible   = req_valid_i & ~resp_valid_q;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned i = 0; i < NrRequesters; i++) begin
            if (!pick_found && eligible[i] && (IdW'(i) >= rr_ptr_q)) begin
                pick_found = 1'b1;
                pick_id    = IdW'(i);
            end
        end
        for (int unsigned i = 0; i < NrRequesters; i++) begin
            if (!pick_found && eligible[i]) begin
                pick_found = 1'b1;
                pick_id    = IdW'(i);
            end
        end
        pick_vaddr = '0;
        for (int unsigned i = 0; i < NrRequesters; i++) begin
            if (IdW'(i) == pick_id) begin
                pick_vaddr = req_vaddr_i[i*VLEN +: VLEN];
            end
        end
    end

    assign handshake    = ptw_valid_q & ptw_ready_i;
    assign timeout      = (cnt_q == CntW'(TimeoutCycles - 1));
    assign grant_onehot = NrRequesters'(1) << grant_id_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        vaddr_d      = vaddr_q;
        cnt_d        = cnt_q;
        resp_valid_d = '0;
        resp_error_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_id;
                    vaddr_d    = pick_vaddr;
                    rr_ptr_d   = (pick_id == IdW'(NrRequesters - 1)) ? '0 : pick_id + IdW'(1);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // A flush racing the handshake leaves a walk in flight that
                // must be drained before the walker can be reused.
                if (handshake && flush_i) begin
                    state_d = DRAIN;
                end else if (handshake) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = timeout ? cnt_q : cnt_q + CntW'(1);
                // Completion beats both flush and the watchdog; a flush only
                // suppresses the response.
                if (ptw_done_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        resp_valid_d = grant_onehot;
                        resp_error_d = ptw_error_i;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end else if (timeout) begin
                    resp_valid_d = grant_onehot;
                    resp_error_d = 1'b1;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (ptw_done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ptw_valid_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            vaddr_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= '0;
            resp_error_q <= 1'b0;
            ptw_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            vaddr_q      <= vaddr_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            ptw_valid_q  <= ptw_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_error_o = resp_error_q;
    assign ptw_valid_o  = ptw_valid_q;
    assign ptw_vaddr_o  = vaddr_q;
    assign ptw_id_o     = grant_id_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_ptw_req_arbiter.sv
module tb_ptw_req_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned VL = 39;
    localparam int unsigned TO = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic [N-1:0]      req_valid_i;
    logic [N*VL-1:0]   req_vaddr_i;
    logic [N-1:0]      resp_valid_o;
    logic              resp_error_o;
    logic              ptw_valid_o;
    logic              ptw_ready_i;
    logic [VL-1:0]     ptw_vaddr_o;
    logic [0:0]        ptw_id_o;
    logic              ptw_done_i;
    logic              ptw_error_i;
    logic              busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ptw_req_arbiter #(
        .NrRequesters (N),
        .VLEN         (VL),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_vaddr_i (req_vaddr_i),
        .resp_valid_o(resp_valid_o),
        .resp_error_o(resp_error_o),
        .ptw_valid_o (ptw_valid_o),
        .ptw_ready_i (ptw_ready_i),
        .ptw_vaddr_o (ptw_vaddr_o),
        .ptw_id_o    (ptw_id_o),
        .ptw_done_i  (ptw_done_i),
        .ptw_error_i (ptw_error_i),
        .busy_o      (busy_o)
    );

    // ptw_done_i must only arrive while a walk is outstanding.
    always @(negedge clk_i) begin
        if (!rst_i && ptw_done_i && (!busy_o || ptw_valid_o)) begin
            $display("FAIL protocol: ptw_done_i seen with busy=%0b valid=%0b, required busy=1 valid=0",
                     busy_o, ptw_valid_o);
            n_fail++;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = '0;
        req_vaddr_i = '0;
        ptw_ready_i = 1'b0;
        ptw_done_i  = 1'b0;
        ptw_error_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        flush_i     = 1'b1;
        req_valid_i = 2'b11;
        req_vaddr_i = {39'h55_5555_5000, 39'h2A_AAAA_A000};
        ptw_ready_i = 1'b1;
        ptw_done_i  = 1'b0;
        ptw_error_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ptw_valid_o !== 1'b0 || resp_valid_o !== 2'b00 || resp_error_o !== 1'b0 ||
            busy_o !== 1'b0 || ptw_vaddr_o !== '0 || ptw_id_o !== 1'b0) begin
            $display("FAIL reset_outputs: valid=%b resp=%b err=%b busy=%b vaddr=%h id=%b, required all zero",
                     ptw_valid_o, resp_valid_o, resp_error_o, busy_o, ptw_vaddr_o, ptw_id_o);
            n_fail++;
        end
        do_reset();
    endtask

    task automatic test_single_itlb();
        do_reset();
        req_vaddr_i[0 +: VL] = 39'h40_0000_1000;
        req_valid_i = 2'b01;                            // cycle 0
        tick();                                         // cycle 1
        n_checks++;
        if (ptw_valid_o !== 1'b1 || ptw_id_o !== 1'b0 || ptw_vaddr_o !== 39'h40_0000_1000 || busy_o !== 1'b1) begin
            $display("FAIL single_issue: valid=%b id=%0d vaddr=%h busy=%b, required valid=1 id=0 vaddr=4000001000 busy=1",
                     ptw_valid_o, ptw_id_o, ptw_vaddr_o, busy_o);
            n_fail++;
        end
        tick();                                         // cycle 2
        n_checks++;
        if (ptw_valid_o !== 1'b1) begin
            $display("FAIL single_hold: valid=%b, required 1", ptw_valid_o);
            n_fail++;
        end
        ptw_ready_i = 1'b1;
        tick();                                         // cycle 3
        ptw_ready_i = 1'b0;
        n_checks++;
        if (ptw_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            $display("FAIL single_wait: valid=%b busy=%b, required valid=0 busy=1", ptw_valid_o, busy_o);
            n_fail++;
        end
        tick();
        tick();
        tick();                                         // cycle 6
        ptw_done_i  = 1'b1;
        ptw_error_i = 1'b0;
        tick();                                         // cycle 7
        ptw_done_i = 1'b0;
        n_checks++;
        if (resp_valid_o !== 2'b01 || resp_error_o !== 1'b0 || busy_o !== 1'b0) begin
            $display("FAIL single_resp: resp=%b err=%b busy=%b, required resp=01 err=0 busy=0",
                     resp_valid_o, resp_error_o, busy_o);
            n_fail++;
        end
        tick();                                         // cycle 8, request still held from cycle 7
        n_checks++;
        if (ptw_valid_o !== 1'b0 || resp_valid_o !== 2'b00) begin
            $display("FAIL single_mask: valid=%b resp=%b, required valid=0 resp=00", ptw_valid_o, resp_valid_o);
            n_fail++;
        end
        req_valid_i = 2'b00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [VL-1:0] exp_vaddr;
        int unsigned   exp_id;
        int            waited;
        logic          got;
        do_reset();
        req_vaddr_i = {39'h22_2222_2000, 39'h11_1111_1000};
        req_valid_i = 2'b11;
        for (int g = 0; g < 3; g++) begin
            exp_id    = unsigned'(g % 2);
            exp_vaddr = (exp_id == 0) ? 39'h11_1111_1000 : 39'h22_2222_2000;
            waited    = 0;
            got       = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                tick();
                waited++;
                if (ptw_valid_o === 1'b1) got = 1'b1;
            end
            n_checks++;
            if (!got || waited != 1) begin
                $display("FAIL rr_latency_%0d: valid after %0d cycles (seen=%b), required 1 cycle", g, waited, got);
                n_fail++;
            end
            n_checks++;
            if (ptw_id_o !== exp_id[0] || ptw_vaddr_o !== exp_vaddr) begin
                $display("FAIL rr_grant_%0d: id=%0d vaddr=%h, required id=%0d vaddr=%h",
                         g, ptw_id_o, ptw_vaddr_o, exp_id, exp_vaddr);
                n_fail++;
            end
            ptw_ready_i = 1'b1;
            tick();
            ptw_ready_i = 1'b0;
            tick();
            ptw_done_i = 1'b1;
            tick();
            ptw_done_i = 1'b0;
            n_checks++;
            if (resp_valid_o !== (2'b01 << exp_id) || resp_error_o !== 1'b0) begin
                $display("FAIL rr_resp_%0d: resp=%b err=%b, required resp=%b err=0",
                         g, resp_valid_o, resp_error_o, 2'b01 << exp_id);
                n_fail++;
            end
        end
        req_valid_i = 2'b00;
    endtask

    task automatic test_flush_issue();
        logic seen;
        do_reset();
        req_vaddr_i[VL +: VL] = 39'h7F_FFFF_F000;
        req_valid_i = 2'b10;
        tick();
        n_checks++;
        if (ptw_valid_o !== 1'b1 || ptw_id_o !== 1'b1 || ptw_vaddr_o !== 39'h7F_FFFF_F000) begin
            $display("FAIL flush_issue_grant: valid=%b id=%0d vaddr=%h, required valid=1 id=1 vaddr=7ffffff000",
                     ptw_valid_o, ptw_id_o, ptw_vaddr_o);
            n_fail++;
        end
        flush_i     = 1'b1;
        req_valid_i = 2'b00;
        tick();
        flush_i = 1'b0;
        n_checks++;
        if (ptw_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            $display("FAIL flush_issue_drop: valid=%b busy=%b, required valid=0 busy=0", ptw_valid_o, busy_o);
            n_fail++;
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid_o !== 2'b00) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen) begin
            $display("FAIL flush_issue_noresp: response observed=%b, required 0", seen);
            n_fail++;
        end
    endtask

    task automatic test_flush_wait();
        do_reset();
        req_vaddr_i = {39'h33_0000_5000, 39'h44_0000_6000};
        req_valid_i = 2'b11;
        tick();                                         // cycle 1
        n_checks++;
        if (ptw_valid_o !== 1'b1 || ptw_id_o !== 1'b0) begin
            $display("FAIL flush_wait_grant: valid=%b id=%0d, required valid=1 id=0", ptw_valid_o, ptw_id_o);
            n_fail++;
        end
        ptw_ready_i = 1'b1;
        tick();                                         // cycle 2, WAIT
        ptw_ready_i = 1'b0;
        flush_i     = 1'b1;
        req_valid_i = 2'b10;
        tick();                                         // cycle 3, DRAIN
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (busy_o !== 1'b1 || ptw_valid_o !== 1'b0 || resp_valid_o !== 2'b00) begin
                $display("FAIL flush_wait_drain_%0d: busy=%b valid=%b resp=%b, required busy=1 valid=0 resp=00",
                         i, busy_o, ptw_valid_o, resp_valid_o);
                n_fail++;
            end
            tick();                                     // cycles 4, 5
        end
        ptw_done_i = 1'b1;                              // cycle 5: late done
        tick();                                         // cycle 6
        ptw_done_i = 1'b0;
        n_checks++;
        if (resp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
            $display("FAIL flush_wait_idle: resp=%b busy=%b, required resp=00 busy=0", resp_valid_o, busy_o);
            n_fail++;
        end
        tick();                                         // cycle 7
        n_checks++;
        if (ptw_valid_o !== 1'b1 || ptw_id_o !== 1'b1 || ptw_vaddr_o !== 39'h33_0000_5000) begin
            $display("FAIL flush_wait_dtlb: valid=%b id=%0d vaddr=%h, required valid=1 id=1 vaddr=3300005000",
                     ptw_valid_o, ptw_id_o, ptw_vaddr_o);
            n_fail++;
        end
        req_valid_i = 2'b00;
    endtask

    task automatic test_timeout();
        logic early;
        do_reset();
        req_vaddr_i[0 +: VL] = 39'h0A_BCDE_F000;
        req_valid_i = 2'b01;
        tick();                                         // cycle 1
        ptw_ready_i = 1'b1;                             // handshake in cycle 1
        tick();                                         // cycle 2, first WAIT cycle
        ptw_ready_i = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (resp_valid_o !== 2'b00) early = 1'b1;
            tick();
        end                                             // cycle 9, eighth WAIT cycle
        if (resp_valid_o !== 2'b00) early = 1'b1;
        n_checks++;
        if (early) begin
            $display("FAIL timeout_early: response before timeout=%b, required 0", early);
            n_fail++;
        end
        tick();                                         // cycle 10
        n_checks++;
        if (resp_valid_o !== 2'b01 || resp_error_o !== 1'b1 || busy_o !== 1'b1) begin
            $display("FAIL timeout_resp: resp=%b err=%b busy=%b, required resp=01 err=1 busy=1",
                     resp_valid_o, resp_error_o, busy_o);
            n_fail++;
        end
        tick();                                         // cycle 11
        req_valid_i = 2'b00;
        n_checks++;
        if (resp_valid_o !== 2'b00 || resp_error_o !== 1'b0 || busy_o !== 1'b1) begin
            $display("FAIL timeout_pulse: resp=%b err=%b busy=%b, required resp=00 err=0 busy=1",
                     resp_valid_o, resp_error_o, busy_o);
            n_fail++;
        end
        tick();
        tick();
        tick();                                         // cycle 14
        n_checks++;
        if (busy_o !== 1'b1 || ptw_valid_o !== 1'b0) begin
            $display("FAIL timeout_drain: busy=%b valid=%b, required busy=1 valid=0", busy_o, ptw_valid_o);
            n_fail++;
        end
        ptw_done_i = 1'b1;
        tick();                                         // cycle 15
        ptw_done_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || resp_valid_o !== 2'b00) begin
            $display("FAIL timeout_late_done: busy=%b resp=%b, required busy=0 resp=00", busy_o, resp_valid_o);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_wait_corners();
        do_reset();
        req_vaddr_i = {39'h3F_0000_4000, 39'h00_0000_3000};
        req_valid_i = 2'b01;
        tick();                                         // cycle 1
        ptw_ready_i = 1'b1;
        tick();                                         // cycle 2
        ptw_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();             // cycle 9, timeout cycle
        ptw_done_i  = 1'b1;
        ptw_error_i = 1'b0;
        tick();                                         // cycle 10
        ptw_done_i = 1'b0;
        n_checks++;
        if (resp_valid_o !== 2'b01 || resp_error_o !== 1'b0 || busy_o !== 1'b0) begin
            $display("FAIL done_beats_timeout: resp=%b err=%b busy=%b, required resp=01 err=0 busy=0",
                     resp_valid_o, resp_error_o, busy_o);
            n_fail++;
        end
        req_valid_i = 2'b10;
        tick();                                         // cycle 11
        n_checks++;
        if (ptw_valid_o !== 1'b1 || ptw_id_o !== 1'b1 || ptw_vaddr_o !== 39'h3F_0000_4000) begin
            $display("FAIL corner_grant1: valid=%b id=%0d vaddr=%h, required valid=1 id=1 vaddr=3f00004000",
                     ptw_valid_o, ptw_id_o, ptw_vaddr_o);
            n_fail++;
        end
        ptw_ready_i = 1'b1;
        tick();                                         // cycle 12, WAIT
        ptw_ready_i = 1'b0;
        ptw_done_i  = 1'b1;
        ptw_error_i = 1'b1;
        flush_i     = 1'b1;
        tick();                                         // cycle 13
        ptw_done_i  = 1'b0;
        ptw_error_i = 1'b0;
        flush_i     = 1'b0;
        n_checks++;
        if (resp_valid_o !== 2'b00 || resp_error_o !== 1'b0 || busy_o !== 1'b0) begin
            $display("FAIL flush_with_done: resp=%b err=%b busy=%b, required resp=00 err=0 busy=0",
                     resp_valid_o, resp_error_o, busy_o);
            n_fail++;
        end
        tick();                                         // cycle 14
        n_checks++;
        if (ptw_valid_o !== 1'b1 || ptw_id_o !== 1'b1) begin
            $display("FAIL corner_regrant: valid=%b id=%0d, required valid=1 id=1", ptw_valid_o, ptw_id_o);
            n_fail++;
        end
        ptw_ready_i = 1'b1;
        tick();                                         // cycle 15
        ptw_ready_i = 1'b0;
        ptw_done_i  = 1'b1;
        ptw_error_i = 1'b1;
        tick();                                         // cycle 16
        ptw_done_i  = 1'b0;
        ptw_error_i = 1'b0;
        n_checks++;
        if (resp_valid_o !== 2'b10 || resp_error_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL fault_resp: resp=%b err=%b busy=%b, required resp=10 err=1 busy=0",
                     resp_valid_o, resp_error_o, busy_o);
            n_fail++;
        end
        req_valid_i = 2'b00;
        tick();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        req_vaddr_i = {39'h65_4321_0000, 39'h12_3456_7000};
        req_valid_i = 2'b01;
        tick();                                         // cycle 1
        ptw_ready_i = 1'b1;
        tick();                                         // cycle 2, WAIT
        ptw_ready_i = 1'b0;
        rst_i       = 1'b1;
        tick();                                         // cycle 3
        rst_i = 1'b0;
        n_checks++;
        if (ptw_valid_o !== 1'b0 || resp_valid_o !== 2'b00 || resp_error_o !== 1'b0 ||
            busy_o !== 1'b0 || ptw_vaddr_o !== '0 || ptw_id_o !== 1'b0) begin
            $display("FAIL rst_wait_outputs: valid=%b resp=%b err=%b busy=%b vaddr=%h id=%b, required all zero",
                     ptw_valid_o, resp_valid_o, resp_error_o, busy_o, ptw_vaddr_o, ptw_id_o);
            n_fail++;
        end
        req_valid_i = 2'b11;
        tick();                                         // cycle 4
        n_checks++;
        if (ptw_valid_o !== 1'b1 || ptw_id_o !== 1'b0 || ptw_vaddr_o !== 39'h12_3456_7000) begin
            $display("FAIL rst_wait_rrptr: valid=%b id=%0d vaddr=%h, required valid=1 id=0 vaddr=1234567000",
                     ptw_valid_o, ptw_id_o, ptw_vaddr_o);
            n_fail++;
        end
        ptw_ready_i = 1'b1;
        tick();                                         // cycle 5
        ptw_ready_i = 1'b0;
        tick();                                         // cycle 6
        ptw_done_i = 1'b1;
        tick();                                         // cycle 7
        ptw_done_i = 1'b0;
        n_checks++;
        if (resp_valid_o !== 2'b01 || resp_error_o !== 1'b0) begin
            $display("FAIL rst_wait_resp: resp=%b err=%b, required resp=01 err=0", resp_valid_o, resp_error_o);
            n_fail++;
        end
        req_valid_i = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_itlb();
        test_round_robin();
        test_flush_issue();
        test_flush_wait();
        test_timeout();
        test_wait_corners();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ptw_req_arbiter.md
Name: ptw_req_arbiter

Overview:
- Shares the single page-table walker (PTW) between N TLB-miss requesters. Default N=2: ITLB index 0, DTLB index 1 (Sv39, 16-entry TLBs).
- Round-robin grant; one walk outstanding at a time.
- Routes the walk response back to the granted requester.
- Handles flush aborts and a walk-timeout watchdog so a hung walk cannot stall the MMU.

Parameters:
- NrRequesters, 2, number of TLB-miss sources (≥2).
- VLEN, 39, virtual address width (Sv39).
- TimeoutCycles, 1024, WAIT cycles before a walk is declared failed (≥2).
- IdW, $clog2(NrRequesters), requester index width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  abort pending/outstanding walk (sfence.vma / hfence / exception).
- req_valid_i  in  NrRequesters  miss request per requester; held until its resp_valid_o.
- req_vaddr_i  in  NrRequesters*VLEN  packed miss vaddr; slice i belongs to requester i.
- resp_valid_o  out  NrRequesters  one-cycle pulse: walk for requester i finished.
- resp_error_o  out  1  walk faulted or timed out; qualified by any resp_valid_o bit.
- ptw_valid_o  out  1  walk request to PTW.
- ptw_ready_i  in  1  PTW accepts request (handshake when valid&ready).
- ptw_vaddr_o  out  VLEN  latched vaddr of granted requester.
- ptw_id_o  out  IdW  granted requester index.
- ptw_done_i  in  1  PTW walk completed (single-cycle).
- ptw_error_i  in  1  walk fault; valid with ptw_done_i.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant_id=0, timeout counter=0. All outputs 0: ptw_valid_o, resp_valid_o, resp_error_o, busy_o, ptw_vaddr_o, ptw_id_o.
- State machine: IDLE, ISSUE, WAIT, DRAIN. All outputs registered.
- IDLE:
  - Eligible = req_valid_i, with the bit whose resp_valid_o is high this cycle masked off (requester drops valid one cycle late).
  - If any eligible bit: grant the first set bit searching upward from rr_ptr, wrapping modulo NrRequesters.
  - On grant: latch grant_id and its vaddr slice; rr_ptr <= (grant_id+1) mod N; go to ISSUE.
  - Request at cycle 0 → ptw_valid_o=1 at cycle 1.
- ISSUE:
  - ptw_valid_o=1; ptw_vaddr_o/ptw_id_o stable.
  - On ptw_valid_o&ptw_ready_i: go to WAIT and clear the counter.
  - flush_i (no handshake this cycle): drop ptw_valid_o next cycle, go to IDLE, no response.
  - flush_i and handshake in the same cycle: go to DRAIN.
- WAIT:
  - Counter increments each cycle.
  - ptw_done_i: next cycle resp_valid_o[grant_id]=1 and resp_error_o=ptw_error_i, go to IDLE.
  - flush_i without ptw_done_i: go to DRAIN, no response.
  - flush_i with ptw_done_i in the same cycle: response is suppressed, go to IDLE.
  - Counter reaches TimeoutCycles-1 without done: next cycle resp_valid_o[grant_id]=1, resp_error_o=1, go to DRAIN.
  - ptw_done_i arriving on the timeout cycle has priority over the timeout.
- DRAIN:
  - Waits for the late ptw_done_i, then goes to IDLE. No response and no new grant until then.
  - flush_i ignored.
- Response latency: ptw_done_i at cycle k → resp_valid_o at k+1. Earliest next ptw_valid_o is at k+2.
- Only one resp_valid_o bit is ever high. resp_error_o is 0 whenever no bit is set.
- ptw_done_i in IDLE/ISSUE is a protocol violation; ignore it (assertion in bench).
- rst_i mid-walk: returns to the reset state next cycle; the outstanding walk is forgotten.
- Counter saturates and does not wrap.

Test Plan:
- Single ITLB miss, vaddr 0x40_0000_1000: ptw_valid_o at cycle 1; ready at 2; done at 6 with error=0 → resp_valid_o=2'b01 at cycle 7, resp_error_o=0, busy_o=0 at 7.
- Both requesters valid continuously from reset: grants alternate. 1st id=0, 2nd id=1, 3rd id=0 (rr_ptr wraps). No requester granted twice back-to-back while the other is pending.
- flush_i while in ISSUE with ptw_ready_i=0: ptw_valid_o=0 next cycle, state IDLE, no resp_valid_o ever.
- flush_i in WAIT: DRAIN; done 3 cycles later → no response; state IDLE the cycle after done; pending DTLB request then granted.
- TimeoutCycles=8, PTW never asserts done: resp_valid_o[id]=1 with resp_error_o=1 exactly 8 cycles after the handshake, then DRAIN. A late done returns to IDLE with no second response.
- rst_i asserted in WAIT: next cycle all outputs 0, rr_ptr=0; a subsequent request is granted normally.
